// File: rtl/psum_acc.sv
// Partial-sum accumulator: sums K_PASSES passes of 16x16 lanes into one of two ping-pong
// banks with 24-bit saturation, then streams the finished tile to ppu one row per cycle.
module psum_acc #(
    parameter int unsigned PSUM_W   = 20,
    parameter int unsigned K_PASSES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_psum_valid,
    input  logic [16*PSUM_W-1:0] i_psum_data,
    output logic                 o_psum_ready,
    output logic                 o_ppu_start,
    output logic [24*16-1:0]     o_acc_data,
    output logic [7:0]           o_tile_cnt
);

    localparam int unsigned KW = (K_PASSES > 1) ? $clog2(K_PASSES) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StStream} state_e;

    // Row storage indexed by {bank, row}
    logic [24*16-1:0] mem [32];

    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [3:0]        wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic [KW-1:0]     kp_q, kp_d;
    logic [1:0]        full_q, full_d;
    logic              ready_q, ready_d;
    logic              start_q;
    logic [7:0]        tile_cnt_q, tile_cnt_d;
    state_e            state_q, state_d;
    logic              accept, last_beat, drain_done;
    logic [24*16-1:0]  old_row, wr_row_data;
    logic [23:0]       lane_ext [16];
    logic signed [24:0] lane_sum [16];

    assign accept    = i_psum_valid & ready_q;
    assign last_beat = (wr_row_q == 4'd15) && (kp_q == KW'(K_PASSES - 1));
    assign old_row   = mem[{wr_bank_q, wr_row_q}];

    always_comb begin
        wr_row_data = '0;
        for (int g = 0; g < 16; g++) begin
            lane_ext[g] = 24'(signed'(i_psum_data[g*PSUM_W +: PSUM_W]));
            lane_sum[g] = 25'(signed'(old_row[g*24 +: 24])) + 25'(signed'(lane_ext[g]));
            if (kp_q == '0) begin
                wr_row_data[g*24 +: 24] = lane_ext[g];
            end else if (lane_sum[g][24] != lane_sum[g][23]) begin
                wr_row_data[g*24 +: 24] = lane_sum[g][24] ? 24'h800000 : 24'h7fffff;
            end else begin
                wr_row_data[g*24 +: 24] = lane_sum[g][23:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[{wr_bank_q, wr_row_q}] <= wr_row_data;
        end
    end

    // Fill side counters and bank-full bookkeeping
    always_comb begin
        wr_row_d  = wr_row_q;
        kp_d      = kp_q;
        wr_bank_d = wr_bank_q;
        if (accept) begin
            wr_row_d = wr_row_q + 4'd1;
            if (wr_row_q == 4'd15) begin
                if (last_beat) begin
                    kp_d      = '0;
                    wr_bank_d = ~wr_bank_q;
                end else begin
                    kp_d = kp_q + KW'(1);
                end
            end
        end
        full_d = full_q;
        if (accept && last_beat) full_d[wr_bank_q] = 1'b1;
        if (drain_done)          full_d[rd_bank_q] = 1'b0;
        ready_d = ~full_d[wr_bank_d];
    end

    always_comb begin
        state_d    = state_q;
        rd_row_d   = rd_row_q;
        rd_bank_d  = rd_bank_q;
        tile_cnt_d = tile_cnt_q;
        drain_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) state_d = StStart;
            end
            StStart: begin
                rd_row_d = 4'd0;
                state_d  = StStream;
            end
            StStream: begin
                rd_row_d = rd_row_q + 4'd1;
                if (rd_row_q == 4'd15) begin
                    drain_done = 1'b1;
                    rd_bank_d  = ~rd_bank_q;
                    tile_cnt_d = tile_cnt_q + 8'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_row_q   <= 4'd0;
            rd_row_q   <= 4'd0;
            kp_q       <= '0;
            full_q     <= 2'b00;
            ready_q    <= 1'b0;
            start_q    <= 1'b0;
            tile_cnt_q <= 8'd0;
            state_q    <= StIdle;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_row_q   <= wr_row_d;
            rd_row_q   <= rd_row_d;
            kp_q       <= kp_d;
            full_q     <= full_d;
            ready_q    <= ready_d;
            start_q    <= (state_d == StStart);
            tile_cnt_q <= tile_cnt_d;
            state_q    <= state_d;
        end
    end

    assign o_psum_ready = ready_q;
    assign o_ppu_start  = start_q;
    assign o_tile_cnt   = tile_cnt_q;
    assign o_acc_data   = (state_q == StStream) ? mem[{rd_bank_q, rd_row_q}] : '0;

endmodule

// File: tb/tb_psum_acc.sv
// Scoreboard bench for psum_acc: a tile-level reference model queues expected rows,
// an independent monitor checks the streamed output, start spacing, ready and tile count.
module tb_psum_acc;

    localparam int PW = 20;
    localparam int KP = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           psum_valid;
    logic [16*PW-1:0] psum_data;
    logic           o_psum_ready, o_ppu_start;
    logic [383:0]   o_acc_data;
    logic [7:0]     o_tile_cnt;

    logic           s_valid;
    logic [383:0]   s_data;
    logic           s_ready, s_start;
    logic [383:0]   s_acc;
    logic [7:0]     s_cnt;

    always #5 clk = ~clk;

    psum_acc #(.PSUM_W(PW), .K_PASSES(KP)) dut (
        .i_clk(clk), .i_rst(rst), .i_psum_valid(psum_valid), .i_psum_data(psum_data),
        .o_psum_ready(o_psum_ready), .o_ppu_start(o_ppu_start), .o_acc_data(o_acc_data),
        .o_tile_cnt(o_tile_cnt)
    );

    // Wide-lane instance so that saturation is reachable within a few passes
    psum_acc #(.PSUM_W(24), .K_PASSES(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_psum_valid(s_valid), .i_psum_data(s_data),
        .o_psum_ready(s_ready), .o_ppu_start(s_start), .o_acc_data(s_acc), .o_tile_cnt(s_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input logic cond);
        checks++;
        if (cond !== 1'b1) begin
            errors++;
            $display("FAIL %s actual=0 required=1", name);
        end
    endtask

    function automatic int clamp24(input int v);
        if (v > 8388607) return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    // Reference model: whole-tile integer accumulation
    int m_acc [16][16];
    int m_row = 0, m_kp = 0, filled = 0, drained = 0, exp_tiles = 0;
    logic [383:0] exp_q [$];

    function automatic int lane20(input logic [16*PW-1:0] d, input int g);
        logic signed [PW-1:0] x;
        x = d[g*PW +: PW];
        return int'(x);
    endfunction

    task automatic model_beat(input logic [16*PW-1:0] d);
        logic [383:0] p;
        for (int g = 0; g < 16; g++) begin
            if (m_kp == 0) m_acc[m_row][g] = lane20(d, g);
            else           m_acc[m_row][g] = clamp24(m_acc[m_row][g] + lane20(d, g));
        end
        m_row++;
        if (m_row == 16) begin
            m_row = 0;
            m_kp++;
            if (m_kp == KP) begin
                m_kp = 0;
                for (int r = 0; r < 16; r++) begin
                    for (int g = 0; g < 16; g++) p[g*24 +: 24] = 24'(m_acc[r][g]);
                    exp_q.push_back(p);
                end
                filled++;
            end
        end
    endtask

    // Monitor
    int   strm = -1;
    int   cyc = 0;
    int   last_start = -100;
    logic rst_prev = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            strm = -1;
            drained = 0;
            exp_tiles = 0;
            last_start = -100;
            check("reset_outputs", {o_ppu_start, o_psum_ready, o_tile_cnt, o_acc_data}, '0);
        end else begin
            if (strm >= 0 && strm < 16) begin
                if (exp_q.size() == 0) check_true("row_expected", 1'b0);
                else check("stream_row", o_acc_data, exp_q.pop_front());
                if (strm == 15) exp_tiles++;
                strm++;
            end else if (strm == 16) begin
                check("post_stream_zero", o_acc_data, '0);
                drained++;
                check("tile_cnt", o_tile_cnt, 8'(exp_tiles));
                strm = -1;
            end else if (!o_ppu_start) begin
                check("idle_zero", o_acc_data, '0);
            end
            if (o_ppu_start) begin
                check("start_zero", o_acc_data, '0);
                check_true("start_legal",
                           strm == -1 && (cyc - last_start) >= 18 && exp_q.size() >= 16);
                last_start = cyc;
                strm = 0;
            end
            check("ready", o_psum_ready, !rst_prev && (filled - drained) < 2);
        end
        rst_prev = rst;
    end

    // Driver
    task automatic drive_beat(input logic v, input logic [16*PW-1:0] d, output logic acc);
        @(negedge clk);
        psum_valid = v;
        psum_data  = d;
        acc = v && o_psum_ready;
        @(posedge clk);
        #1;
        if (acc) model_beat(d);
    endtask

    function automatic logic [16*PW-1:0] gen(input int mode);
        logic [16*PW-1:0] d;
        for (int g = 0; g < 16; g++) begin
            if (mode == 0)      d[g*PW +: PW] = PW'(100);
            else if (mode < 4)  d[g*PW +: PW] = PW'(mode);
            else                d[g*PW +: PW] = PW'($urandom);
        end
        return d;
    endfunction

    task automatic send_beats(input int mode, input int n, input int stall_pct);
        int got = 0;
        int tries = 0;
        logic acc, v;
        logic [16*PW-1:0] d;
        while (got < n && tries < n * 20 + 100) begin
            v = ($urandom_range(99) >= stall_pct);
            d = v ? gen(mode) : gen(4);
            drive_beat(v, d, acc);
            if (acc) got++;
            tries++;
        end
        psum_valid = 1'b0;
        check_true("beats_accepted", got == n);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) drive_beat(1'b0, gen(4), acc);
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && strm == -1) break;
        end
        check_true("drained", exp_q.size() == 0 && strm == -1);
    endtask

    task automatic wait_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_ppu_start) break;
        end
        check_true("start_seen", o_ppu_start);
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1;
        psum_valid = 1'b0;
        m_row = 0;
        m_kp = 0;
        filled = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    function automatic int sat_val(input int r, input int p, input int g);
        case (g)
            0: return 8388607;
            1: return -8388608;
            2: return (p == 0) ? 8388607 : -1;
            3: return (p == 0) ? -8388608 : 1;
            default: return r * 37 - g * 11 + p * 5;
        endcase
    endfunction

    int s_m [16][16];

    initial begin
        logic [383:0] srow;
        rst = 1'b1;
        psum_valid = 1'b0;
        psum_data = '0;
        s_valid = 1'b0;
        s_data = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;

        send_beats(0, 64, 0);                   // all lanes 100 -> 400
        wait_drained();
        send_beats(4, 64, 40);                  // random with stalls
        send_beats(4, 64, 0);
        send_beats(1, 64, 0);                   // ping-pong with per-tile constants
        send_beats(2, 64, 0);
        send_beats(3, 64, 0);
        wait_drained();

        send_beats(4, 64, 0);                   // reset mid-stream at row 7
        wait_start();
        repeat (8) @(posedge clk);
        do_reset();
        idle(30);
        send_beats(4, 64, 20);
        wait_drained();

        send_beats(4, 37, 0);                   // reset mid-fill in pass 2
        do_reset();
        idle(30);
        send_beats(0, 64, 0);
        wait_drained();

        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 16; r++) begin
                @(negedge clk);
                s_valid = 1'b1;
                for (int g = 0; g < 16; g++) begin
                    s_data[g*24 +: 24] = 24'(sat_val(r, p, g));
                    s_m[r][g] = (p == 0) ? sat_val(r, p, g)
                                         : clamp24(s_m[r][g] + sat_val(r, p, g));
                end
                check_true("sat_ready", s_ready);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (s_start) break;
            @(negedge clk);
        end
        check_true("sat_start", s_start);
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            for (int g = 0; g < 16; g++) srow[g*24 +: 24] = 24'(s_m[r][g]);
            check("sat_row", s_acc, srow);
        end
        @(negedge clk);
        check("sat_tile_cnt", s_cnt, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
